// File: rtl/voice_allocator.sv
// Voice allocator: hands each accepted note request to the lowest free note_player voice.
// When every voice is busy it either evicts the oldest voice (STEAL=1) or stalls the requester.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int AGE_WIDTH  = 8,
    parameter bit STEAL      = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic                  beat,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [5:0]            req_note,
    input  logic [5:0]            req_duration,
    input  logic [1:0]            req_stereo,
    input  logic [NUM_VOICES-1:0] voice_done,
    output logic [NUM_VOICES-1:0] voice_load,
    output logic [5:0]            note_out,
    output logic [5:0]            duration_out,
    output logic [1:0]            stereo_out,
    output logic [NUM_VOICES-1:0] busy,
    output logic [3:0]            active_count,
    output logic                  steal_pulse
);

    localparam int IDX_W = $clog2(NUM_VOICES);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        LOAD
    } state_e;

    state_e                state_q, state_d;
    logic [5:0]            note_q, note_d;
    logic [5:0]            dur_q, dur_d;
    logic [1:0]            st_q, st_d;
    logic [IDX_W-1:0]      target_q, target_d;
    logic                  steal_q, steal_d;
    logic [NUM_VOICES-1:0] voice_load_q, voice_load_d;
    logic [5:0]            note_out_q, note_out_d;
    logic [5:0]            duration_out_q, duration_out_d;
    logic [1:0]            stereo_out_q, stereo_out_d;
    logic [NUM_VOICES-1:0] busy_q, busy_d;
    logic [3:0]            active_count_q, active_count_d;
    logic                  steal_pulse_q, steal_pulse_d;
    logic [AGE_WIDTH-1:0]  age_q [NUM_VOICES];
    logic [AGE_WIDTH-1:0]  age_d [NUM_VOICES];

    logic [NUM_VOICES-1:0] free_set;
    logic                  any_free;
    logic [IDX_W-1:0]      free_idx;
    logic [IDX_W-1:0]      oldest_idx;
    logic [AGE_WIDTH-1:0]  oldest_age;

    // A voice finishing this very cycle is already eligible for the next note.
    always_comb begin
        free_set   = ~busy_q | voice_done;
        any_free   = |free_set;
        free_idx   = '0;
        oldest_idx = '0;
        oldest_age = age_q[0];
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (free_set[i]) free_idx = IDX_W'(i);
        end
        for (int i = 1; i < NUM_VOICES; i++) begin
            if (age_q[i] > oldest_age) begin
                oldest_age = age_q[i];
                oldest_idx = IDX_W'(i);
            end
        end
    end

    assign req_ready = (state_q == IDLE) && play && (STEAL || !(&busy_q));

    // NOTE: every _d signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d        = state_q;
        note_d         = note_q;
        dur_d          = dur_q;
        st_d           = st_q;
        target_d       = target_q;
        steal_d        = steal_q;
        voice_load_d   = '0;
        steal_pulse_d  = 1'b0;
        note_out_d     = note_out_q;
        duration_out_d = duration_out_q;
        stereo_out_d   = stereo_out_q;
        busy_d         = busy_q & ~voice_done;
        for (int i = 0; i < NUM_VOICES; i++) begin
            if (beat && busy_q[i] && (age_q[i] != '1)) age_d[i] = age_q[i] + AGE_WIDTH'(1);
            else                                       age_d[i] = age_q[i];
        end

        case (state_q)
            IDLE: begin
                // Rests are consumed here and never occupy a voice.
                if (req_valid && req_ready && (req_note != '0)) begin
                    note_d  = req_note;
                    dur_d   = req_duration;
                    st_d    = req_stereo;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                target_d = any_free ? free_idx : oldest_idx;
                steal_d  = !any_free;
                state_d  = LOAD;
            end
            LOAD: begin
                voice_load_d[target_q] = 1'b1;
                note_out_d             = note_q;
                duration_out_d         = dur_q;
                stereo_out_d           = st_q;
                busy_d[target_q]       = 1'b1;
                age_d[target_q]        = '0;
                steal_pulse_d          = steal_q;
                state_d                = IDLE;
            end
            default: state_d = IDLE;
        endcase

        active_count_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            active_count_d = active_count_d + 4'(busy_d[i]);
        end
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            note_q         <= '0;
            dur_q          <= '0;
            st_q           <= '0;
            target_q       <= '0;
            steal_q        <= 1'b0;
            voice_load_q   <= '0;
            note_out_q     <= '0;
            duration_out_q <= '0;
            stereo_out_q   <= '0;
            busy_q         <= '0;
            active_count_q <= '0;
            steal_pulse_q  <= 1'b0;
            // NOTE: the age array is a handful of flops that drive eviction, so it is reset too.
            age_q          <= '{default: '0};
        end else begin
            state_q        <= state_d;
            note_q         <= note_d;
            dur_q          <= dur_d;
            st_q           <= st_d;
            target_q       <= target_d;
            steal_q        <= steal_d;
            voice_load_q   <= voice_load_d;
            note_out_q     <= note_out_d;
            duration_out_q <= duration_out_d;
            stereo_out_q   <= stereo_out_d;
            busy_q         <= busy_d;
            active_count_q <= active_count_d;
            steal_pulse_q  <= steal_pulse_d;
            age_q          <= age_d;
        end
    end

    assign voice_load   = voice_load_q;
    assign note_out     = note_out_q;
    assign duration_out = duration_out_q;
    assign stereo_out   = stereo_out_q;
    assign busy         = busy_q;
    assign active_count = active_count_q;
    assign steal_pulse  = steal_pulse_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Directed bench for voice_allocator: a stealing instance (a) and a stalling instance (b),
// with expected loads queued at the handshake and compared when voice_load fires.
module tb_voice_allocator;

    typedef struct {
        logic [3:0] vec;
        logic [5:0] note;
        logic [5:0] dur;
        logic [1:0] st;
        logic       steal;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset, play, beat;
    logic       req_valid_a, req_valid_b;
    logic       req_ready_a, req_ready_b;
    logic [5:0] req_note, req_duration;
    logic [1:0] req_stereo;
    logic [3:0] done_a, done_b;
    logic [3:0] voice_load_a, voice_load_b;
    logic [5:0] note_out_a, note_out_b, dur_out_a, dur_out_b;
    logic [1:0] st_out_a, st_out_b;
    logic [3:0] busy_a, busy_b;
    logic [3:0] count_a, count_b;
    logic       steal_a, steal_b;

    int   n_chk = 0;
    int   n_err = 0;
    exp_t q_a[$];
    exp_t q_b[$];

    always #5 clk = ~clk;

    voice_allocator #(.NUM_VOICES(4), .AGE_WIDTH(8), .STEAL(1'b1)) dut_a (
        .clk(clk), .reset(reset), .play(play), .beat(beat),
        .req_valid(req_valid_a), .req_ready(req_ready_a),
        .req_note(req_note), .req_duration(req_duration), .req_stereo(req_stereo),
        .voice_done(done_a), .voice_load(voice_load_a),
        .note_out(note_out_a), .duration_out(dur_out_a), .stereo_out(st_out_a),
        .busy(busy_a), .active_count(count_a), .steal_pulse(steal_a)
    );

    voice_allocator #(.NUM_VOICES(4), .AGE_WIDTH(8), .STEAL(1'b0)) dut_b (
        .clk(clk), .reset(reset), .play(play), .beat(beat),
        .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_note(req_note), .req_duration(req_duration), .req_stereo(req_stereo),
        .voice_done(done_b), .voice_load(voice_load_b),
        .note_out(note_out_b), .duration_out(dur_out_b), .stereo_out(st_out_b),
        .busy(busy_b), .active_count(count_b), .steal_pulse(steal_b)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic send(input bit which, input logic [5:0] n, input logic [5:0] d,
                        input logic [1:0] s, input logic [3:0] vec, input logic stl,
                        input bit push, output int waited);
        logic rdy;
        exp_t e;
        req_note     = n;
        req_duration = d;
        req_stereo   = s;
        if (which) req_valid_b = 1'b1;
        else       req_valid_a = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            rdy = which ? req_ready_b : req_ready_a;
            if (rdy === 1'b1 || waited >= 40) break;
            waited++;
        end
        if (rdy !== 1'b1) begin
            check(which ? "b_handshake_timeout" : "a_handshake_timeout", 32'(rdy), 1);
        end else if (push) begin
            e = '{vec: vec, note: n, dur: d, st: s, steal: stl};
            if (which) q_b.push_back(e);
            else       q_a.push_back(e);
        end
        step();
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && (voice_load_a !== 4'b0 || steal_a !== 1'b0)) begin
            if (q_a.size() == 0) begin
                check("a_unexpected_load", {voice_load_a, steal_a}, 0);
            end else begin
                e = q_a.pop_front();
                check("a_load_vec", voice_load_a, e.vec);
                check("a_load_note", note_out_a, e.note);
                check("a_load_dur", dur_out_a, e.dur);
                check("a_load_st", st_out_a, e.st);
                check("a_load_steal", steal_a, e.steal);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (!reset && (voice_load_b !== 4'b0 || steal_b !== 1'b0)) begin
            if (q_b.size() == 0) begin
                check("b_unexpected_load", {voice_load_b, steal_b}, 0);
            end else begin
                e = q_b.pop_front();
                check("b_load_vec", voice_load_b, e.vec);
                check("b_load_note", note_out_b, e.note);
                check("b_load_dur", dur_out_b, e.dur);
                check("b_load_st", st_out_b, e.st);
                check("b_load_steal", steal_b, e.steal);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   w;
        exp_t e;
        reset        = 1'b1;
        play         = 1'b0;
        beat         = 1'b0;
        req_valid_a  = 1'b0;
        req_valid_b  = 1'b0;
        req_note     = '0;
        req_duration = '0;
        req_stereo   = '0;
        done_a       = '0;
        done_b       = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("a_rst_busy", busy_a, 0);
        check("a_rst_count", count_a, 0);
        check("a_rst_load", voice_load_a, 0);
        check("a_rst_note", note_out_a, 0);
        check("a_rst_steal", steal_a, 0);
        check("a_ready_no_play", req_ready_a, 0);
        step();
        play = 1'b1;
        @(negedge clk);
        check("a_ready_play", req_ready_a, 1);
        step();

        // First note: load two cycles after the handshake edge.
        send(0, 6'd10, 6'd4, 2'd1, 4'b0001, 1'b0, 1, w);
        @(negedge clk);
        check("t1_load_cycle0", voice_load_a, 0);
        step();
        @(negedge clk);
        check("t1_load_cycle1", voice_load_a, 0);
        step();
        @(negedge clk);
        check("t1_load_cycle2", voice_load_a, 4'b0001);
        check("t1_note", note_out_a, 10);
        check("t1_dur", dur_out_a, 4);
        check("t1_st", st_out_a, 1);
        check("t1_busy", busy_a, 4'b0001);
        check("t1_count", count_a, 1);
        step();

        // Back-to-back fill, one handshake every three cycles.
        done_a = 4'b0001;
        step();
        done_a = '0;
        for (int i = 0; i < 4; i++) begin
            send(0, 6'(i + 1), 6'(2 * i + 3), 2'(i), 4'(1 << i), 1'b0, 1, w);
            if (i > 0) check("t2_spacing", w, 2);
        end
        repeat (3) step();
        @(negedge clk);
        check("t2_busy", busy_a, 4'b1111);
        check("t2_count", count_a, 4);
        check("t2_ready_all_busy", req_ready_a, 1);
        step();

        // Ages: all reach 5, voices 0/1/3 reloaded, two more beats -> voice 2 is oldest.
        repeat (5) begin
            beat = 1'b1;
            step();
            beat = 1'b0;
            step();
        end
        done_a = 4'b1011;
        step();
        done_a = '0;
        @(negedge clk);
        check("t3_busy_after_done", busy_a, 4'b0100);
        check("t3_count_after_done", count_a, 1);
        step();
        send(0, 6'd11, 6'd1, 2'd0, 4'b0001, 1'b0, 1, w);
        send(0, 6'd12, 6'd2, 2'd1, 4'b0010, 1'b0, 1, w);
        send(0, 6'd13, 6'd3, 2'd2, 4'b1000, 1'b0, 1, w);
        repeat (3) step();
        repeat (2) begin
            beat = 1'b1;
            step();
            beat = 1'b0;
            step();
        end
        send(0, 6'd30, 6'd5, 2'd2, 4'b0100, 1'b1, 1, w);
        repeat (3) step();
        // Voice 2 age was cleared, so the tie among 0/1/3 goes to voice 0.
        send(0, 6'd31, 6'd6, 2'd3, 4'b0001, 1'b1, 1, w);
        repeat (3) step();
        @(negedge clk);
        check("t3_busy", busy_a, 4'b1111);
        check("t3_count", count_a, 4);
        step();

        // Rest is accepted and dropped; FSM stays in IDLE.
        send(0, 6'd0, 6'd7, 2'd1, 4'b0000, 1'b0, 0, w);
        @(negedge clk);
        check("t4_rest_stays_idle", req_ready_a, 1);
        step();
        repeat (2) step();
        @(negedge clk);
        check("t4_rest_busy", busy_a, 4'b1111);
        step();

        // voice_done[3] during SELECT beats the older voice 1.
        send(0, 6'd40, 6'd8, 2'd2, 4'b1000, 1'b0, 1, w);
        done_a = 4'b1000;
        step();
        done_a = '0;
        repeat (3) step();
        @(negedge clk);
        check("t4_busy", busy_a, 4'b1111);
        step();

        // Reset while in SELECT aborts the load.
        send(0, 6'd50, 6'd9, 2'd1, 4'b0000, 1'b0, 0, w);
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_no_load", voice_load_a, 0);
            step();
        end
        @(negedge clk);
        check("t5_busy", busy_a, 0);
        check("t5_count", count_a, 0);
        check("t5_idle_ready", req_ready_a, 1);
        check("t5_steal", steal_a, 0);
        step();

        // play low blocks acceptance.
        play        = 1'b0;
        req_note    = 6'd5;
        req_valid_a = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t6_ready_play_low", req_ready_a, 0);
            step();
        end
        req_valid_a = 1'b0;
        play        = 1'b1;
        repeat (3) step();
        @(negedge clk);
        check("t6_busy", busy_a, 0);
        step();

        // Stalling instance: fill, hold a request, free voice 1.
        @(negedge clk);
        check("b_start_busy", busy_b, 0);
        check("b_start_ready", req_ready_b, 1);
        step();
        for (int i = 0; i < 4; i++) begin
            send(1, 6'(20 + i), 6'd3, 2'd0, 4'(1 << i), 1'b0, 1, w);
        end
        repeat (3) step();
        @(negedge clk);
        check("b_full_busy", busy_b, 4'b1111);
        check("b_full_count", count_b, 4);
        check("b_full_ready", req_ready_b, 0);
        step();
        req_note     = 6'd44;
        req_duration = 6'd12;
        req_stereo   = 2'd3;
        req_valid_b  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("b_stall_ready", req_ready_b, 0);
            step();
        end
        e = '{vec: 4'b0010, note: 6'd44, dur: 6'd12, st: 2'd3, steal: 1'b0};
        q_b.push_back(e);
        done_b = 4'b0010;
        @(negedge clk);
        check("b_ready_done_cycle", req_ready_b, 0);
        step();
        done_b = '0;
        @(negedge clk);
        check("b_ready_after_done", req_ready_b, 1);
        check("b_busy_after_done", busy_b, 4'b1101);
        step();
        req_valid_b = 1'b0;
        repeat (4) step();
        @(negedge clk);
        check("b_final_busy", busy_b, 4'b1111);
        check("b_final_count", count_b, 4);
        step();

        repeat (4) step();
        check("a_queue_drained", q_a.size(), 0);
        check("b_queue_drained", q_b.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
